bf_io_responder: RTL and testbench

- Target side of the CPU's io_req/io_ack byte I/O handshake; the `,` and `.` instructions terminate here.
- Input bytes come from a host-side ready/valid stream and are buffered in an RX FIFO; CPU reads pop from it.
- CPU writes push into a TX FIFO, drained by a host-side ready/valid stream.
- Sits beside the CPU in the top level, in place of a testbench I/O model.

---
 rtl/bf_io_responder_pkg.sv | 15 +
 rtl/bf_io_responder_if.sv | 36 +++
 rtl/bf_io_responder_byte_fifo.sv | 63 ++++++
 rtl/bf_io_responder.sv | 103 ++++++++++
 tb/tb_bf_io_responder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bf_io_responder_pkg.sv
// Shared encodings for the CPU byte I/O responder:
// transfer direction and responder FSM states.
package bf_io_responder_pkg;

  typedef enum logic {
    DIRECTION_READ  = 1'b0,
    DIRECTION_WRITE = 1'b1
  } io_dir_e;

  typedef enum logic {
    IO_RSP_IDLE = 1'b0,
    IO_RSP_ACK  = 1'b1
  } io_rsp_state_e;

endpackage

// File: rtl/bf_io_responder_if.sv
// CPU io_req/io_ack bus plus host RX/TX byte streams.
// slave = responder side, master = CPU/host side.
interface bf_io_responder_if;

  logic       io_req;
  logic       io_dir;
  logic [7:0] io_wdata;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_eof;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport slave (
    input  io_req, io_dir, io_wdata,
    output io_ack, io_rdata,
    input  rx_valid, rx_data, rx_eof,
    output rx_ready,
    output tx_valid, tx_data,
    input  tx_ready
  );

  modport master (
    output io_req, io_dir, io_wdata,
    input  io_ack, io_rdata,
    output rx_valid, rx_data, rx_eof,
    input  rx_ready,
    input  tx_valid, tx_data,
    output tx_ready
  );

endinterface

// File: rtl/bf_io_responder_byte_fifo.sv
// Byte FIFO with wrap-around pointers, a count register
// and full/empty flags registered from the next count.
module byte_fifo #(
  parameter int depth_log2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] full_cnt =
    (depth_log2 + 1)'(depth);

  logic [7:0]            mem [depth];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic [depth_log2:0]   count;
  logic [depth_log2:0]   count_nxt;
  logic                  do_push;
  logic                  do_pop;

  // a full FIFO still takes a push when a pop frees a slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == full_cnt);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bf_io_responder.sv
// Target side of the CPU io_req/io_ack byte I/O handshake,
// bridging to host RX/TX ready/valid streams via FIFOs.
module bf_io_responder
  import bf_io_responder_pkg::*;
#(
  parameter int         fifo_depth_log2 = 4,
  parameter logic [7:0] eof_value       = 8'h00
) (
  input logic               clk,
  input logic               rst_n,
  bf_io_responder_if.slave  bus
);

  io_rsp_state_e state;

  logic       rx_empty;
  logic       rx_full;
  logic [7:0] rx_head;
  logic       tx_empty;
  logic       tx_full;
  logic       rx_pop;
  logic       tx_push;
  logic       req_idle;
  logic       is_wr;
  logic       wr_go;
  logic       rd_go;
  logic       eof_go;

  assign req_idle = (state == IO_RSP_IDLE) && bus.io_req;
  assign is_wr    = (bus.io_dir == DIRECTION_WRITE);
  assign wr_go    = req_idle && is_wr && !tx_full;
  assign rd_go    = req_idle && !is_wr && !rx_empty;
  assign eof_go   = req_idle && !is_wr && rx_empty
                    && bus.rx_eof;

  assign tx_push = wr_go;
  assign rx_pop  = rd_go;

  assign bus.rx_ready = !rx_full;
  assign bus.tx_valid = !tx_empty;

  byte_fifo #(.depth_log2(fifo_depth_log2)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.rx_valid && !rx_full),
    .push_data (bus.rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  byte_fifo #(.depth_log2(fifo_depth_log2)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (bus.io_wdata),
    .pop       (bus.tx_ready && !tx_empty),
    .pop_data  (bus.tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // io_rdata only loads on the IDLE->ACK edge, so it is
  // stable for the whole ack window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IO_RSP_IDLE;
      bus.io_ack   <= 1'b0;
      bus.io_rdata <= 8'h00;
    end else begin
      unique case (state)
        IO_RSP_IDLE: begin
          unique case (1'b1)
            wr_go: begin
              bus.io_ack <= 1'b1;
              state      <= IO_RSP_ACK;
            end
            rd_go: begin
              bus.io_rdata <= rx_head;
              bus.io_ack   <= 1'b1;
              state        <= IO_RSP_ACK;
            end
            eof_go: begin
              bus.io_rdata <= eof_value;
              bus.io_ack   <= 1'b1;
              state        <= IO_RSP_ACK;
            end
            default: ;
          endcase
        end
        IO_RSP_ACK: begin
          if (!bus.io_req) begin
            bus.io_ack <= 1'b0;
            state      <= IO_RSP_IDLE;
          end
        end
        default: state <= IO_RSP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_io_responder.sv
// Directed bench for bf_io_responder: write, read, stall,
// EOF, TX full/wrap and reset during an ack.
module tb_bf_io_responder;
  import bf_io_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  bf_io_responder_if bus();

  bf_io_responder #(
    .fifo_depth_log2 (4),
    .eof_value       (8'hFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk)
    if (rst_n && bus.tx_valid && bus.tx_ready)
      txq.push_back(bus.tx_data);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input string tag,
                        input logic dir,
                        input logic [7:0] wd,
                        input logic [7:0] exp_rd,
                        input int max,
                        output int cyc);
    bus.io_req   = 1'b1;
    bus.io_dir   = dir;
    bus.io_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.io_ack && cyc < max);
    if (!bus.io_ack) begin
      cyc = 99;
      bus.io_req = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      if (dir == DIRECTION_READ)
        chk({tag, "_rd"}, bus.io_rdata, exp_rd);
      @(negedge clk);
      chk({tag, "_hold_ack"}, bus.io_ack, 1'b1);
      if (dir == DIRECTION_READ)
        chk({tag, "_hold_rd"}, bus.io_rdata, exp_rd);
      bus.io_req = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_fall"}, bus.io_ack, 1'b0);
    end
  endtask

  task automatic cpu_stall(input string tag, input int n);
    int acks;
    acks = 0;
    bus.io_req = 1'b1;
    bus.io_dir = DIRECTION_READ;
    repeat (n) begin
      @(negedge clk);
      if (bus.io_ack) acks++;
    end
    bus.io_req = 1'b0;
    repeat (2) @(negedge clk);
    chk(tag, acks, 0);
  endtask

  task automatic rx_push(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acks;
    bus.io_req   = 1'b0;
    bus.io_dir   = DIRECTION_READ;
    bus.io_wdata = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_eof   = 1'b0;
    bus.tx_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ack", bus.io_ack, 1'b0);
    chk("rst_rdata", bus.io_rdata, 8'h00);
    chk("rst_rx_ready", bus.rx_ready, 1'b1);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // write 0x41 with host draining
    bus.tx_ready = 1'b1;
    cpu_op("wr41", DIRECTION_WRITE, 8'h41, 8'h00, 4, cyc);
    chk("wr41_lat", cyc, 1);
    repeat (3) @(negedge clk);
    chk("wr41_cnt", txq.size(), 1);
    if (txq.size() > 0) chk("wr41_data", txq[0], 8'h41);
    txq.delete();

    // two reads
    rx_push(8'h05);
    rx_push(8'h07);
    cpu_op("rd05", DIRECTION_READ, 8'h00, 8'h05, 4, cyc);
    chk("rd05_lat", cyc, 1);
    cpu_op("rd07", DIRECTION_READ, 8'h00, 8'h07, 4, cyc);
    chk("rd07_lat", cyc, 1);

    // stall on empty RX, then released by a push
    bus.io_req = 1'b1;
    bus.io_dir = DIRECTION_READ;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.io_ack) acks++;
    end
    chk("stall_ack", acks, 0);
    rx_push(8'h33);
    cyc = 1;
    while (!bus.io_ack && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_lat", cyc, 2);
    chk("stall_rd", bus.io_rdata, 8'h33);
    bus.io_req = 1'b0;
    @(negedge clk);
    chk("stall_fall", bus.io_ack, 1'b0);

    // EOF read
    bus.rx_eof = 1'b1;
    cpu_op("eof", DIRECTION_READ, 8'h00, 8'hFF, 4, cyc);
    chk("eof_lat", cyc, 1);
    bus.rx_eof = 1'b0;
    cpu_stall("eof_no_pop", 5);

    // TX full and pointer wrap
    bus.tx_ready = 1'b0;
    txq.delete();
    for (int i = 0; i < 16; i++) begin
      cpu_op("fill", DIRECTION_WRITE, 8'(i), 8'h00, 4, cyc);
      chk("fill_lat", cyc, 1);
    end
    bus.io_req   = 1'b1;
    bus.io_dir   = DIRECTION_WRITE;
    bus.io_wdata = 8'd16;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.io_ack) acks++;
    end
    chk("full_stall", acks, 0);
    bus.tx_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.io_ack && cyc < 5);
    chk("full_release_lat", cyc, 2);
    bus.io_req = 1'b0;
    repeat (25) @(negedge clk);
    chk("drain_cnt", txq.size(), 17);
    for (int i = 0; i < 17; i++)
      if (i < txq.size()) chk("drain_data", txq[i], i);

    // reset during an ack
    bus.tx_ready = 1'b0;
    txq.delete();
    cpu_op("pre_rst_wr", DIRECTION_WRITE, 8'h55, 8'h00, 4, cyc);
    rx_push(8'hAA);
    rx_push(8'hBB);
    rx_push(8'hCC);
    bus.io_req = 1'b1;
    bus.io_dir = DIRECTION_READ;
    @(negedge clk);
    chk("mid_ack", bus.io_ack, 1'b1);
    chk("mid_rd", bus.io_rdata, 8'hAA);
    chk("mid_tx_valid", bus.tx_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ack", bus.io_ack, 1'b0);
    chk("rst2_rx_ready", bus.rx_ready, 1'b1);
    chk("rst2_tx_valid", bus.tx_valid, 1'b0);
    chk("rst2_rdata", bus.io_rdata, 8'h00);
    rst_n = 1'b1;
    bus.io_req = 1'b0;
    @(negedge clk);
    cpu_stall("rst2_rx_empty", 6);
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2_tx_lost", txq.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
